// File: rtl/skinny_sbox8_dom1_serial_ctrl_pkg.sv
// Shared types and constants for the serial DOM1 S-box sequencer.
package skinny_sbox8_dom1_serial_ctrl_pkg;

    localparam int SBOX_W    = 8;
    localparam int SBOX_LAT  = 2;
    localparam int RND_W_DEF = 25;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        EVAL_A = 3'd2,
        EVAL_B = 3'd3,
        FLUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/skinny_sbox8_dom1_serial_ctrl_if.sv
// Randomness handshake plus the bus to the shared masked S-box.
interface skinny_sbox8_dom1_serial_ctrl_if
    import skinny_sbox8_dom1_serial_ctrl_pkg::*;
#(
    parameter int RND_W = RND_W_DEF
);
    logic [RND_W-1:0]  rnd;
    logic              rnd_valid;
    logic              rnd_ready;
    logic [SBOX_W-1:0] sbox_si0;
    logic [SBOX_W-1:0] sbox_si1;
    logic [RND_W-1:0]  sbox_r;
    logic [SBOX_W-1:0] sbox_bo0;
    logic [SBOX_W-1:0] sbox_bo1;

    // master is the sequencer, slave is the randomness source / S-box side
    modport master (
        input  rnd, rnd_valid, sbox_bo0, sbox_bo1,
        output rnd_ready, sbox_si0, sbox_si1, sbox_r
    );
    modport slave (
        output rnd, rnd_valid, sbox_bo0, sbox_bo1,
        input  rnd_ready, sbox_si0, sbox_si1, sbox_r
    );
endinterface

// File: rtl/skinny_sbox8_byte_mux.sv
// Byte select of both state shares plus an enabled in-place write-back.
module skinny_sbox8_byte_mux
    import skinny_sbox8_dom1_serial_ctrl_pkg::*;
#(
    parameter int NBYTES = 16,
    parameter int IW     = 4
) (
    input  logic [SBOX_W*NBYTES-1:0] st0,
    input  logic [SBOX_W*NBYTES-1:0] st1,
    input  logic [IW-1:0]            rd_idx,
    output logic [SBOX_W-1:0]        rd0,
    output logic [SBOX_W-1:0]        rd1,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_idx,
    input  logic [SBOX_W-1:0]        wr0,
    input  logic [SBOX_W-1:0]        wr1,
    output logic [SBOX_W*NBYTES-1:0] nxt0,
    output logic [SBOX_W*NBYTES-1:0] nxt1
);
    assign rd0 = st0[rd_idx*SBOX_W +: SBOX_W];
    assign rd1 = st1[rd_idx*SBOX_W +: SBOX_W];

    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
        logic sel;
        assign sel = wr_en && (wr_idx == IW'(b));
        assign nxt0[b*SBOX_W +: SBOX_W] = sel ? wr0 : st0[b*SBOX_W +: SBOX_W];
        assign nxt1[b*SBOX_W +: SBOX_W] = sel ? wr1 : st1[b*SBOX_W +: SBOX_W];
    end
endmodule

// File: rtl/skinny_sbox8_dom1_serial_ctrl.sv
// Serial sequencer feeding a 2-share state byte-by-byte through one DOM1 S-box.
// Optional SKINNY_SBOX_CTRL_ZERO_IDLE_EN zeroes S-box inputs/mask outside evaluation.
module skinny_sbox8_dom1_serial_ctrl
    import skinny_sbox8_dom1_serial_ctrl_pkg::*;
#(
    parameter int NBYTES = 16,
    parameter int RND_W  = RND_W_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SBOX_W*NBYTES-1:0]        si0,
    input  logic [SBOX_W*NBYTES-1:0]        si1,
    skinny_sbox8_dom1_serial_ctrl_if.master sb,
    output logic [SBOX_W*NBYTES-1:0]        so0,
    output logic [SBOX_W*NBYTES-1:0]        so1,
    output logic                            busy,
    output logic                            done
);
    localparam int            IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t                    state, state_n;
    logic [IW-1:0]             idx, idx_n, wr_idx;
    logic                      cap_pend, rdy, r_ld, done_q;
    logic [RND_W-1:0]          r_hold;
    logic [SBOX_W*NBYTES-1:0]  st0, st1, nxt0, nxt1;
    logic [SBOX_W-1:0]         rd0, rd1, bsi0, bsi1;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        rdy     = 1'b0;
        r_ld    = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                state_n = WAIT;
                idx_n   = '0;
            end
            WAIT: begin
                rdy = 1'b1;
                if (sb.rnd_valid) begin
                    r_ld    = 1'b1;
                    state_n = EVAL_A;
                end
            end
            EVAL_A: state_n = EVAL_B;
            EVAL_B: begin
                if (idx == LAST) begin
                    state_n = FLUSH;
                end else begin
                    rdy     = 1'b1;
                    r_ld    = sb.rnd_valid;
                    idx_n   = idx + 1'b1;
                    state_n = sb.rnd_valid ? EVAL_A : WAIT;
                end
            end
            FLUSH:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The S-box result lands one cycle after EVAL_B; the last byte keeps idx.
    assign wr_idx = (state == FLUSH) ? idx : idx - 1'b1;

    skinny_sbox8_byte_mux #(.NBYTES(NBYTES), .IW(IW)) u_mux (
        .st0    (st0),
        .st1    (st1),
        .rd_idx (idx_n),
        .rd0    (rd0),
        .rd1    (rd1),
        .wr_en  (cap_pend),
        .wr_idx (wr_idx),
        .wr0    (sb.sbox_bo0),
        .wr1    (sb.sbox_bo1),
        .nxt0   (nxt0),
        .nxt1   (nxt1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cap_pend <= 1'b0;
            r_hold   <= '0;
            st0      <= '0;
            st1      <= '0;
            bsi0     <= '0;
            bsi1     <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cap_pend <= (state == EVAL_B);
            done_q   <= (state == FLUSH);
            if (state == IDLE && start) begin
                st0 <= si0;
                st1 <= si1;
            end else begin
                st0 <= nxt0;
                st1 <= nxt1;
            end
            if (r_ld) r_hold <= sb.rnd;
`ifdef SKINNY_SBOX_CTRL_ZERO_IDLE_EN
            else if (state == FLUSH) r_hold <= '0;
`endif
            // Inputs are loaded once on entry to EVAL_A and held through EVAL_B.
            if (state_n == EVAL_A) begin
                bsi0 <= rd0;
                bsi1 <= rd1;
            end
`ifdef SKINNY_SBOX_CTRL_ZERO_IDLE_EN
            else if (state_n != EVAL_B) begin
                bsi0 <= '0;
                bsi1 <= '0;
            end
`endif
        end
    end

    assign sb.rnd_ready = rdy;
    assign sb.sbox_si0  = bsi0;
    assign sb.sbox_si1  = bsi1;
`ifdef SKINNY_SBOX_CTRL_ZERO_IDLE_EN
    assign sb.sbox_r    = (state == EVAL_A || state == EVAL_B) ? r_hold : '0;
`else
    assign sb.sbox_r    = r_hold;
`endif
    assign so0  = st0;
    assign so1  = st1;
    assign busy = (state != IDLE);
    assign done = done_q;
endmodule

// File: tb/tb_skinny_sbox8_dom1_serial_ctrl.sv
// Bench: masked S-box model, cycle-level expectation model and directed runs.
module tb_skinny_sbox8_dom1_serial_ctrl;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [127:0]  si0 = '0, si1 = '0;
    logic [127:0]  so0, so1;
    logic          busy, done;
    int            n_chk = 0, n_fail = 0;
    int            cyc = 0, hs_cnt = 0, done_cnt = 0, start_cyc = 0, exp_lat = 0;

    skinny_sbox8_dom1_serial_ctrl_if #(.RND_W(25)) sb ();

    skinny_sbox8_dom1_serial_ctrl #(.NBYTES(NB), .RND_W(25)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .si0   (si0),
        .si1   (si1),
        .sb    (sb),
        .so0   (so0),
        .so1   (so1),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SKINNY-128 8-bit S-box from its NOR/XOR + bit-permutation definition.
    function automatic logic [7:0] sbox8(input logic [7:0] a);
        logic [7:0] x;
        x = a;
        for (int i = 0; i < 4; i++) begin
            x = x ^ ((~(((x >> 1) | x) >> 2)) & 8'h11);
            if (i < 3)
                x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
                    ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
        end
        return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Masked S-box with 2-cycle latency: output is only correct when the
    // inputs were held for two consecutive cycles, otherwise it is corrupted.
    logic [40:0] sb_in_q = '0;
    always @(posedge clk) begin
        sb.sbox_bo0 <= sbox8(sb_in_q[40:33] ^ sb_in_q[32:25]) ^ sb_in_q[7:0] ^
                       (({sb.sbox_si0, sb.sbox_si1, sb.sbox_r} == sb_in_q) ? 8'h00 : 8'h5A);
        sb.sbox_bo1 <= sb_in_q[7:0];
        sb_in_q     <= {sb.sbox_si0, sb.sbox_si1, sb.sbox_r};
    end

    // Expectation model: counts accepted masks and remaining eval cycles.
    bit           m_on = 0, m_run = 0, m_done = 0, m_zero = 0, m_fl = 0;
    int           m_acc = 0, m_ev = 0;
    logic [127:0] m_sh0 = '0, m_sh1 = '0;
    logic [7:0]   m_l0 = '0, m_l1 = '0;
    logic [24:0]  m_r = '0, m_lr = '0;

    always @(negedge clk) begin
        bit          ev_now, rdy_e, hs;
        logic [7:0]  e0, e1;
        logic [24:0] er;
        logic [127:0] ex;
        ev_now = 0; rdy_e = 0; hs = 0;
        if (m_on) begin
            ev_now = m_run && m_ev > 0;
            rdy_e  = m_run && m_ev <= 1 && m_acc < NB;
            if (ev_now) begin
                e0 = m_sh0[8*(m_acc-1) +: 8];
                e1 = m_sh1[8*(m_acc-1) +: 8];
                er = m_r;
            end else begin
`ifdef SKINNY_SBOX_CTRL_ZERO_IDLE_EN
                e0 = '0; e1 = '0; er = '0;
`else
                e0 = m_l0; e1 = m_l1; er = m_lr;
`endif
            end
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("rnd_ready", sb.rnd_ready, rdy_e);
            chk("sbox_si0", sb.sbox_si0, e0);
            chk("sbox_si1", sb.sbox_si1, e1);
            chk("sbox_r", sb.sbox_r, er);
            if (ev_now) begin m_l0 = e0; m_l1 = e1; m_lr = er; end
            if (m_zero) begin
                chk("so0_zero", so0, 128'h0);
                chk("so1_zero", so1, 128'h0);
            end
            if (m_done) begin
                for (int b = 0; b < NB; b++) ex[8*b +: 8] = sbox8(m_sh0[8*b +: 8] ^ m_sh1[8*b +: 8]);
                chk("result", so0 ^ so1, ex);
                chk("latency", cyc - start_cyc, exp_lat);
                chk("rnd_hs", hs_cnt, NB);
            end
            hs = rdy_e && sb.rnd_valid;
        end
        if (sb.rnd_valid === 1'b1 && sb.rnd_ready === 1'b1) hs_cnt++;
        if (done === 1'b1) done_cnt++;
        if (rst) begin
            m_on = 1; m_run = 0; m_done = 0; m_zero = 1; m_fl = 0; m_ev = 0;
            m_l0 = '0; m_l1 = '0; m_lr = '0; m_r = '0;
        end else begin
            m_zero = 0; m_done = 0;
            if (!m_run) begin
                if (start) begin
                    m_run = 1; m_acc = 0; m_ev = 0; m_fl = 0;
                    m_sh0 = si0; m_sh1 = si1; hs_cnt = 0; start_cyc = cyc;
                end
            end else if (m_fl) begin
                m_run = 0; m_fl = 0; m_done = 1;
            end else if (hs) begin
                m_acc++; m_ev = 2; m_r = sb.rnd;
            end else if (m_ev == 1 && m_acc == NB) begin
                m_ev = 0; m_fl = 1;
            end else if (m_ev > 0) begin
                m_ev--;
            end
        end
    end

    task automatic run(input logic [127:0] p, input bit msk, input int stall_from,
                       input int stall_len, input bit hold, input int rst_at, input int lat);
        logic [127:0] m;
        int d0;
        m = msk ? {$urandom, $urandom, $urandom, $urandom} : 128'h0;
        exp_lat = lat;
        d0 = done_cnt;
        @(posedge clk); #1;
        si0 = p ^ m; si1 = m; start = 1'b1;
        sb.rnd_valid = 1'b1; sb.rnd = 25'($urandom);
        for (int c = 1; c < 120; c++) begin
            @(posedge clk); #1;
            start = hold && c <= 33;
            rst   = (c == rst_at);
            si0   = {$urandom, $urandom, $urandom, $urandom};
            si1   = {$urandom, $urandom, $urandom, $urandom};
            sb.rnd = 25'($urandom);
            sb.rnd_valid = !(c >= stall_from && c < stall_from + stall_len);
            if (rst_at > 0 && c == rst_at + 3) break;
            if (done_cnt != d0) break;
        end
        start = 1'b0; rst = 1'b0; sb.rnd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", done_cnt - d0, (rst_at > 0) ? 0 : 1);
    endtask

    initial begin
        logic [127:0] p;
        sb.rnd = '0; sb.rnd_valid = 1'b0;
        chk("pin_s00", sbox8(8'h00), 8'h65);
        chk("pin_sff", sbox8(8'hFF), 8'hFF);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_so", {so0, so1}, 256'h0);

        run(128'h0, 1'b0, 0, 0, 1'b0, 0, 35);
        chk("zero_res", so0 ^ so1, {16{8'h65}});

        p = {$urandom, $urandom, $urandom, $urandom};
        p[15:0] = 16'hFF00;
        run(p, 1'b1, 0, 0, 1'b0, 0, 35);
        chk("byte0_00", so0[7:0] ^ so1[7:0], 8'h65);
        chk("byte1_ff", so0[15:8] ^ so1[15:8], 8'hFF);

        run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 15, 5, 1'b0, 0, 40);
        run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 0, 1'b0, 12, 0);
        run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 0, 1'b0, 0, 35);
        run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 0, 1'b1, 0, 35);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/skinny_sbox8_dom1_serial_ctrl.md
Name: skinny_sbox8_dom1_serial_ctrl

Overview:
- Sequencer that pushes a 2-share, 128-bit SKINNY cell state through one external 2-cycle, non-pipelined DOM1 8-bit S-box, one byte per evaluation.
- Fetches 25 bits of fresh randomness per byte over a valid/ready handshake and holds the S-box inputs and r stable for exactly 2 cycles.
- Captures the masked output and writes it back in place.
- Sits between the round datapath (SubCells step) and the shared S-box instance.

Parameters:
- NBYTES, 16, number of 8-bit cells processed per start.
- RND_W, 25, randomness bits consumed per S-box evaluation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  load si0/si1 and begin; sampled only in IDLE.
- si0  in  8*NBYTES  state share 0.
- si1  in  8*NBYTES  state share 1.
- rnd  in  RND_W  fresh randomness.
- rnd_valid  in  1  rnd is valid.
- rnd_ready  out  1  controller accepts rnd this cycle.
- sbox_si0  out  8  S-box input, share 0.
- sbox_si1  out  8  S-box input, share 1.
- sbox_r  out  RND_W  S-box refresh mask.
- sbox_bo0  in  8  S-box output, share 0.
- sbox_bo1  in  8  S-box output, share 1.
- so0  out  8*NBYTES  result share 0 (internal state register).
- so1  out  8*NBYTES  result share 1 (internal state register).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when all bytes are written back.

Behaviour:
- Reset: FSM=IDLE, byte index=0, capture-pending=0, state regs=0, r_hold=0, so0/so1=0, busy=0, done=0, rnd_ready=0, sbox_* outputs=0.
- States are IDLE, WAIT, EVAL_A, EVAL_B, FLUSH.
- IDLE:
  - start=1 latches si0/si1 into the state regs, sets idx=0, goes to WAIT.
  - start is ignored in every other state.
- WAIT:
  - rnd_ready=1.
  - rnd_valid=1 latches rnd into r_hold and goes to EVAL_A; otherwise stays.
- EVAL_A, then EVAL_B:
  - sbox_si0/si1 = state byte idx (bits 8*idx+7:8*idx); sbox_r = r_hold. All three are constant across both cycles.
  - EVAL_B: if idx<NBYTES-1, rnd_ready=1.
    - If rnd_valid, latch into r_hold, idx++, go to EVAL_A.
    - Else idx++, go to WAIT.
  - EVAL_B with idx==NBYTES-1: rnd_ready=0, go to FLUSH.
- Capture:
  - capture-pending is set on leaving EVAL_B.
  - In the next cycle, whatever the state (EVAL_A, WAIT or FLUSH), sbox_bo0/bo1 is written into byte idx-1 of the state. For FLUSH the target is the last byte.
  - capture-pending is then cleared. The S-box output is valid in the 3rd cycle after inputs are first applied.
- FLUSH: performs the final capture, then goes to IDLE, pulsing done=1 and dropping busy in that IDLE cycle.
- Throughput and latency with rnd_valid tied high:
  - 2 cycles/byte.
  - start in cycle 0 gives done in cycle 2*NBYTES+3 (35 for NBYTES=16).
  - Exactly NBYTES rnd handshakes per run.
- A rnd_valid stall only lengthens WAIT. Bytes already captured are unaffected.
- Mid-operation rst aborts the run and returns to reset values; no done pulse.
- so0/so1 are valid only after done. Mid-run they hold a mix of processed and unprocessed bytes.

Optional Feature:
- Macro SKINNY_SBOX_CTRL_ZERO_IDLE_EN.
- Defined:
  - sbox_si0, sbox_si1 and sbox_r are forced to 0 in IDLE, WAIT and FLUSH.
  - r_hold is cleared to 0 after the final capture.
  - Purpose: avoid stale-share recombination leakage.
- Undefined: sbox_* outputs keep the last presented byte and mask in non-EVAL states.
- Capture timing is identical in both cases.

Decomposition:
- Shared package holds:
  - FSM state encoding (localparams IDLE..FLUSH);
  - SBOX_W=8;
  - SBOX_LAT=2;
  - the default RND_W=25.
- One sub-module, skinny_sbox8_byte_mux: byte select of the state by idx plus a write-back demux with enable. The FSM, counter and handshake stay in the top module.

Test Plan:
- Zero shares, rnd_valid=1, random rnd, start@0 → done at cycle 35; so0^so1 = 0x65 in every byte; rnd_ready/rnd_valid handshakes = 16.
- Random 128-bit plaintext split into random shares → so0^so1 equals the SKINNY S8 applied per byte; e.g. byte 0xFF→0xFF, 0x00→0x65.
- rnd_valid low for 5 cycles at byte 7 → FSM holds WAIT; sbox_si/sbox_r are stable in each EVAL_A/EVAL_B pair; done is delayed exactly 5 cycles; the result is unchanged.
- Check r stability: sbox_r, sbox_si0 and sbox_si1 are equal in EVAL_A and EVAL_B for all 16 bytes. With SKINNY_SBOX_CTRL_ZERO_IDLE_EN, all three are 0 in WAIT/IDLE/FLUSH.
- rst pulsed at cycle 12 → next cycle: busy=0, so0=so1=0, no done; a subsequent start completes normally.
- start held high continuously and re-asserted while busy → ignored; exactly one done per run; a new run starts only from IDLE.
